// File: rtl/nfc_ecc_gen_if.sv
// Signal bundle between the NAND controller datapath and the ECC engine,
// including the engine's write port into the correction FIFO.
interface nfc_ecc_gen_if #(
  parameter int ECC_DWID = 8,
  parameter int ECC_AWID = 12
);
  logic                nfc_dat_dir;
  logic                ecc_start;
  logic                dat_vld;
  logic [7:0]          dat_in;
  logic                ecc_in_vld;
  logic [ECC_DWID-1:0] ecc_in;
  logic                ecc_fifo_wr;
  logic [ECC_DWID-1:0] ecc_enc_dat;
  logic [ECC_AWID-1:0] ecc_dec_addr;
  logic                ecc_done;
  logic [1:0]          ecc_err_stat;
  logic                ecc_busy;

  modport master (
    output nfc_dat_dir, ecc_start, dat_vld, dat_in, ecc_in_vld, ecc_in,
    input  ecc_fifo_wr, ecc_enc_dat, ecc_dec_addr, ecc_done, ecc_err_stat, ecc_busy
  );

  modport slave (
    input  nfc_dat_dir, ecc_start, dat_vld, dat_in, ecc_in_vld, ecc_in,
    output ecc_fifo_wr, ecc_enc_dat, ecc_dec_addr, ecc_done, ecc_err_stat, ecc_busy
  );
endinterface

// File: rtl/nfc_ecc_gen.sv
// Sector Hamming ECC engine (1-bit correct / 2-bit detect, 3-byte code).
// Encode pushes the 3 code bytes to the FIFO; decode pushes the error bit address.
module nfc_ecc_gen #(
  parameter int ECC_DWID = 8,
  parameter int SECT_AW  = 9,
  parameter int ECC_AWID = SECT_AW + 3
) (
  input  logic         clk_2x,
  input  logic         rst_n,
  nfc_ecc_gen_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_EMIT,
    ST_WAIT_ECC,
    ST_CHECK,
    ST_REPORT,
    ST_DONE
  } state_t;

  state_t                state, state_nxt;
  logic                  dir_q;
  logic [SECT_AW-1:0]    byte_cnt;
  logic [1:0]            sub_cnt;
  logic [SECT_AW-1:0]    lph, lpl;
  logic [2:0]            cph, cpl;
  logic [3*ECC_DWID-1:0] code, stored, syn;
  logic [1:0]            err_stat;
  logic                  start_acc, byte_acc, ecc_acc, last_byte, last_sub;
  logic                  dat_par;
  logic [2:0]            col_h, col_l;
  logic [11:0]           syn_h, syn_l;
  logic [1:0]            syn_class;
  logic [ECC_AWID-1:0]   err_addr;

  assign start_acc = (state == ST_IDLE) && bus.ecc_start;
  assign byte_acc  = (state == ST_ACC) && bus.dat_vld;
  assign ecc_acc   = (state == ST_WAIT_ECC) && bus.ecc_in_vld;
  assign last_byte = byte_acc && (&byte_cnt);
  assign last_sub  = (sub_cnt == 2'd2);

  // Column parities: masks select data bits whose bit index has bit j set (H) or clear (L)
  assign dat_par = ^bus.dat_in;
  assign col_h   = {^(bus.dat_in & 8'hF0), ^(bus.dat_in & 8'hCC), ^(bus.dat_in & 8'hAA)};
  assign col_l   = {^(bus.dat_in & 8'h0F), ^(bus.dat_in & 8'h33), ^(bus.dat_in & 8'h55)};

  always_comb begin
    code = '0;
    for (int k = 0; k < 9; k++) begin
      code[2*k]   = lpl[k];
      code[2*k+1] = lph[k];
    end
    for (int j = 0; j < 3; j++) begin
      code[18+2*j] = cpl[j];
      code[19+2*j] = cph[j];
    end
  end

  // Every code bit sits in an (H,L) pair; a single data-bit error flips exactly one of each pair
  always_comb begin
    syn_h = '0;
    syn_l = '0;
    for (int m = 0; m < 12; m++) begin
      syn_h[m] = syn[2*m+1];
      syn_l[m] = syn[2*m];
    end
    err_addr = {syn_h[8:0], syn_h[11:9]};
    if (syn == '0)                 syn_class = 2'b00;
    else if (&(syn_h ^ syn_l))     syn_class = 2'b01;
    else if ($countones(syn) == 1) syn_class = 2'b11;
    else                           syn_class = 2'b10;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (bus.ecc_start) state_nxt = ST_ACC;
      ST_ACC:      if (last_byte) state_nxt = dir_q ? ST_EMIT : ST_WAIT_ECC;
      ST_EMIT:     if (last_sub) state_nxt = ST_DONE;
      ST_WAIT_ECC: if (ecc_acc && last_sub) state_nxt = ST_CHECK;
      ST_CHECK:    state_nxt = ST_REPORT;
      ST_REPORT:   state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ecc_fifo_wr  = 1'b0;
    bus.ecc_enc_dat  = '0;
    bus.ecc_dec_addr = '0;
    if (state == ST_EMIT) begin
      bus.ecc_fifo_wr = 1'b1;
      bus.ecc_enc_dat = code[sub_cnt*ECC_DWID +: ECC_DWID];
    end else if (state == ST_REPORT && syn_class == 2'b01) begin
      bus.ecc_fifo_wr  = 1'b1;
      bus.ecc_dec_addr = err_addr;
    end
  end

  assign bus.ecc_done     = (state == ST_DONE);
  assign bus.ecc_busy     = (state != ST_IDLE);
  assign bus.ecc_err_stat = err_stat;

  always_ff @(posedge clk_2x or negedge rst_n) begin
    if (!rst_n) begin
      lph <= '0;
      lpl <= '0;
      cph <= '0;
      cpl <= '0;
    end else if (start_acc) begin
      lph <= '0;
      lpl <= '0;
      cph <= '0;
      cpl <= '0;
    end else if (byte_acc) begin
      lph <= lph ^ ({SECT_AW{dat_par}} & byte_cnt);
      lpl <= lpl ^ ({SECT_AW{dat_par}} & ~byte_cnt);
      cph <= cph ^ col_h;
      cpl <= cpl ^ col_l;
    end
  end

  // sub_cnt indexes emitted code bytes in encode and incoming stored bytes in decode
  always_ff @(posedge clk_2x or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dir_q    <= 1'b0;
      byte_cnt <= '0;
      sub_cnt  <= '0;
      stored   <= '0;
      syn      <= '0;
      err_stat <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        dir_q    <= bus.nfc_dat_dir;
        byte_cnt <= '0;
        sub_cnt  <= '0;
        err_stat <= '0;
      end
      if (byte_acc) byte_cnt <= byte_cnt + 1'b1;
      if (state == ST_EMIT) sub_cnt <= last_sub ? 2'd0 : sub_cnt + 2'd1;
      if (ecc_acc) begin
        stored[sub_cnt*ECC_DWID +: ECC_DWID] <= bus.ecc_in;
        sub_cnt <= last_sub ? 2'd0 : sub_cnt + 2'd1;
      end
      if (state == ST_CHECK) syn <= code ^ stored;
      if (state == ST_REPORT) err_stat <= syn_class;
    end
  end

endmodule

// File: tb/tb_nfc_ecc_gen.sv
// Scoreboarded bench for nfc_ecc_gen: whole-sector reference model, random gaps,
// directed sectors, stray control pulses and a mid-sector reset.
module tb_nfc_ecc_gen;

  logic clk_2x = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  nfc_ecc_gen_if bus ();

  nfc_ecc_gen dut (
    .clk_2x(clk_2x),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_2x = ~clk_2x;
  always @(posedge clk_2x) cyc <= cyc + 1;

  typedef struct { logic [7:0] dat; logic [11:0] addr; int cyc; } wr_t;
  typedef struct { logic [1:0] stat; int cyc; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];

  logic [7:0] sector [0:511];

  task automatic tick();
    @(posedge clk_2x);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-sector parity straight from the line/column parity definitions
  function automatic logic [23:0] ref_ecc();
    logic [8:0]  lh = '0;
    logic [8:0]  ll = '0;
    logic [2:0]  ch = '0;
    logic [2:0]  cl = '0;
    logic [23:0] c;
    for (int i = 0; i < 512; i++) begin
      logic p;
      p = ^sector[i];
      for (int k = 0; k < 9; k++)
        if (((i >> k) & 1) == 1) lh[k] ^= p; else ll[k] ^= p;
      for (int b = 0; b < 8; b++)
        for (int j = 0; j < 3; j++)
          if (((b >> j) & 1) == 1) ch[j] ^= sector[i][b]; else cl[j] ^= sector[i][b];
    end
    c[7:0]   = {lh[3], ll[3], lh[2], ll[2], lh[1], ll[1], lh[0], ll[0]};
    c[15:8]  = {lh[7], ll[7], lh[6], ll[6], lh[5], ll[5], lh[4], ll[4]};
    c[23:16] = {ch[2], cl[2], ch[1], cl[1], ch[0], cl[0], lh[8], ll[8]};
    return c;
  endfunction

  function automatic void ref_decode(input logic [23:0] stored, output logic [1:0] st,
                                     output logic [11:0] ad);
    logic [23:0] s;
    bit all_pairs = 1'b1;
    s  = ref_ecc() ^ stored;
    ad = '0;
    for (int m = 0; m < 12; m++) if ((s[2*m] ^ s[2*m+1]) == 1'b0) all_pairs = 1'b0;
    if (s == 0) st = 2'b00;
    else if (all_pairs) begin
      st = 2'b01;
      for (int k = 0; k < 9; k++) ad[3+k] = s[2*k+1];
      for (int j = 0; j < 3; j++) ad[j] = s[19+2*j];
    end else if ($countones(s) == 1) st = 2'b11;
    else st = 2'b10;
  endfunction

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk_2x) begin
    if (rst_n) begin
      if (bus.ecc_fifo_wr) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wr: got write dat 0x%0h addr 0x%0h at cycle %0d, required none",
                   bus.ecc_enc_dat, bus.ecc_dec_addr, cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          checkOutput("wr_dat", bus.ecc_enc_dat, w.dat);
          checkOutput("wr_addr", bus.ecc_dec_addr, w.addr);
          checkOutput("wr_cycle", cyc, w.cyc);
        end
      end
      if (bus.ecc_done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got ecc_done at cycle %0d, required none", cyc);
        end else begin
          done_t d;
          d = done_q.pop_front();
          checkOutput("done_stat", bus.ecc_err_stat, d.stat);
          checkOutput("done_cycle", cyc, d.cyc);
          checkOutput("done_busy", bus.ecc_busy, 1);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.ecc_start  = 1'b0;
    bus.dat_vld    = 1'b0;
    bus.ecc_in_vld = 1'b0;
  endtask

  // One sector: start, data with random gaps and stray pulses, then (decode) the stored bytes
  task automatic applyStimulus(input bit enc, input logic [23:0] stored, input logic [23:0] exp_code,
                               input logic [1:0] exp_stat, input logic [11:0] exp_addr, input int gap_pct);
    int last;
    int t;
    bus.nfc_dat_dir = enc;
    bus.ecc_start   = 1'b1;
    tick();
    bus.ecc_start = 1'b0;
    checkOutput("busy_start", bus.ecc_busy, 1);
    checkOutput("stat_clr", bus.ecc_err_stat, 0);
    for (int i = 0; i < 512;) begin
      if ($urandom_range(99) < gap_pct) begin
        bus.dat_vld = 1'b0;
        bus.dat_in  = 8'($urandom);
      end else begin
        bus.dat_vld = 1'b1;
        bus.dat_in  = sector[i];
        i++;
      end
      bus.nfc_dat_dir = 1'($urandom);
      bus.ecc_in_vld  = 1'($urandom);
      bus.ecc_in      = 8'($urandom);
      bus.ecc_start   = (i == 5) || ($urandom_range(49) == 0);
      tick();
    end
    idle_inputs();
    last = cyc;
    if (enc) begin
      for (int b = 0; b < 3; b++) wr_q.push_back('{exp_code[8*b +: 8], 12'h000, last + b});
      done_q.push_back('{2'b00, last + 3});
      bus.ecc_start = 1'b1;
      tick();
      bus.ecc_start = 1'b0;
    end else begin
      for (int b = 0; b < 3;) begin
        if ($urandom_range(99) < gap_pct) begin
          bus.ecc_in_vld = 1'b0;
          bus.ecc_in     = 8'($urandom);
        end else begin
          bus.ecc_in_vld = 1'b1;
          bus.ecc_in     = stored[8*b +: 8];
          b++;
        end
        bus.dat_vld   = 1'($urandom);
        bus.dat_in    = 8'($urandom);
        bus.ecc_start = ($urandom_range(3) == 0);
        tick();
      end
      idle_inputs();
      last = cyc;
      if (exp_stat == 2'b01) wr_q.push_back('{8'h00, exp_addr, last + 1});
      done_q.push_back('{exp_stat, last + 2});
    end
    t = 0;
    while (done_q.size() != 0 && t < 40) begin
      tick();
      t++;
    end
    if (done_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no ecc_done within 40 cycles, required ecc_done");
      done_q.delete();
    end
    checkOutput("wr_pending", wr_q.size(), 0);
    wr_q.delete();
    tick();
    tick();
    checkOutput("stat_held", bus.ecc_err_stat, exp_stat);
    checkOutput("busy_idle", bus.ecc_busy, 0);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 512; i++) sector[i] = v;
  endtask

  initial begin
    logic [23:0] code;
    logic [23:0] stored;
    logic [1:0]  st;
    logic [11:0] ad;
    int          mode, p0, p1;
    bit          enc;

    bus.nfc_dat_dir = 1'b0;
    bus.dat_in      = 8'h00;
    bus.ecc_in      = 8'h00;
    idle_inputs();
    repeat (2) tick();
    checkOutput("rst_wr", bus.ecc_fifo_wr, 0);
    checkOutput("rst_dat", bus.ecc_enc_dat, 0);
    checkOutput("rst_addr", bus.ecc_dec_addr, 0);
    checkOutput("rst_done", bus.ecc_done, 0);
    checkOutput("rst_stat", bus.ecc_err_stat, 0);
    checkOutput("rst_busy", bus.ecc_busy, 0);
    rst_n = 1'b1;
    bus.dat_vld    = 1'b1;
    bus.dat_in     = 8'hA5;
    bus.ecc_in_vld = 1'b1;
    repeat (3) tick();
    idle_inputs();
    checkOutput("idle_busy", bus.ecc_busy, 0);

    $display("[TB] directed encode sectors");
    fill(8'hFF);
    applyStimulus(1'b1, 24'h0, 24'h000000, 2'b00, 12'h0, 0);
    fill(8'h00);
    sector[0] = 8'h01;
    applyStimulus(1'b1, 24'h0, 24'h555555, 2'b00, 12'h0, 30);

    $display("[TB] directed decode sectors");
    fill(8'h00);
    applyStimulus(1'b0, 24'h000000, 24'h0, 2'b00, 12'h0, 20);
    sector[12'h1A3] = 8'h20;
    applyStimulus(1'b0, 24'h000000, 24'h0, 2'b01, 12'hD1D, 20);
    sector[12'h1A3] = 8'h00;
    applyStimulus(1'b0, 24'h000001, 24'h0, 2'b11, 12'h0, 10);
    sector[12'h010] = 8'h04;
    sector[12'h1F0] = 8'h80;
    applyStimulus(1'b0, 24'h000000, 24'h0, 2'b10, 12'h0, 10);

    $display("[TB] reset in the middle of a sector");
    fill(8'h00);
    bus.nfc_dat_dir = 1'b1;
    bus.ecc_start   = 1'b1;
    tick();
    bus.ecc_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.dat_vld = 1'b1;
      bus.dat_in  = 8'($urandom);
      tick();
    end
    bus.dat_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", bus.ecc_busy, 0);
    checkOutput("abort_done", bus.ecc_done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    sector[0] = 8'h01;
    applyStimulus(1'b1, 24'h0, 24'h555555, 2'b00, 12'h0, 0);

    $display("[TB] randomized sectors");
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 512; i++) sector[i] = 8'($urandom);
      enc  = 1'($urandom);
      code = ref_ecc();
      if (enc) begin
        applyStimulus(1'b1, 24'h0, code, 2'b00, 12'h0, $urandom_range(0, 60));
      end else begin
        stored = code;
        mode   = $urandom_range(3);
        st     = 2'b00;
        ad     = 12'h0;
        if (mode == 1) begin
          p0 = $urandom_range(4095);
          sector[p0/8][p0%8] = ~sector[p0/8][p0%8];
          st = 2'b01;
          ad = 12'(p0);
        end else begin
          if (mode == 2) begin
            p0 = $urandom_range(4095);
            p1 = (p0 + $urandom_range(1, 4095)) % 4096;
            sector[p0/8][p0%8] = ~sector[p0/8][p0%8];
            sector[p1/8][p1%8] = ~sector[p1/8][p1%8];
          end else if (mode == 3) begin
            p0 = $urandom_range(23);
            stored[p0] = ~stored[p0];
          end
          ref_decode(stored, st, ad);
        end
        applyStimulus(1'b0, stored, 24'h0, st, ad, $urandom_range(0, 60));
      end
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
